// File: rtl/lc3b_pkg.sv
// ============================================================================
// Module      : lc3b_pkg
// Description : Shared ALU opcodes, execute-stage state encoding and
//               condition-code reset values for the LC-3b datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3b_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_AND   = 3'd1;
    localparam logic [2:0] ALU_XOR   = 3'd2;
    localparam logic [2:0] ALU_PASSA = 3'd3;
    localparam logic [2:0] ALU_PASSB = 3'd4;
    localparam logic [2:0] ALU_LSHF  = 3'd5;
    localparam logic [2:0] ALU_RSHFL = 3'd6;
    localparam logic [2:0] ALU_RSHFA = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } exec_state_e;

    localparam logic CC_N_RST = 1'b0;
    localparam logic CC_Z_RST = 1'b1;
    localparam logic CC_P_RST = 1'b0;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == ALU_LSHF) || (op == ALU_RSHFL) || (op == ALU_RSHFA);
    endfunction

endpackage : lc3b_pkg

`default_nettype wire

// File: rtl/alu_comb.sv
// ============================================================================
// Module      : alu_comb
// Description : Single-cycle ALU functions plus one 1-bit shift step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_comb
    import lc3b_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_shift_op,
    input  logic [WIDTH-1:0] i_shift_in,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_shift_out
);

    // Shift opcodes fall through to PASSA: a zero-amount shift yields src_a.
    always_comb begin
        o_result = i_a;
        case (i_op)
            ALU_ADD:   o_result = i_a + i_b;
            ALU_AND:   o_result = i_a & i_b;
            ALU_XOR:   o_result = i_a ^ i_b;
            ALU_PASSA: o_result = i_a;
            ALU_PASSB: o_result = i_b;
            default:   o_result = i_a;
        endcase
    end

    always_comb begin
        o_shift_out = i_shift_in;
        case (i_shift_op)
            ALU_LSHF:  o_shift_out = {i_shift_in[WIDTH-2:0], 1'b0};
            ALU_RSHFL: o_shift_out = {1'b0, i_shift_in[WIDTH-1:1]};
            ALU_RSHFA: o_shift_out = {i_shift_in[WIDTH-1], i_shift_in[WIDTH-1:1]};
            default:   o_shift_out = i_shift_in;
        endcase
    end

endmodule : alu_comb

`default_nettype wire

// File: rtl/alu_exec.sv
// ============================================================================
// Module      : alu_exec
// Description : LC-3b execute-stage ALU with start/done handshake, registered
//               result, iterative shifter and N/Z/P condition codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec
    import lc3b_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       aluk,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             ld_cc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             n,
    output logic             z,
    output logic             p
);

    exec_state_e      r_state;
    logic [3:0]       r_count;
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic [2:0]       r_op;
    logic             r_ldcc;
    logic             r_n;
    logic             r_z;
    logic             r_p;

    exec_state_e      w_state_nxt;
    logic [3:0]       w_count_nxt;
    logic [WIDTH-1:0] w_result_nxt;
    logic             w_done_nxt;
    logic [2:0]       w_op_nxt;
    logic             w_ldcc_nxt;
    logic             w_cc_upd;
    logic [WIDTH-1:0] w_comb_res;
    logic [WIDTH-1:0] w_step_res;
    logic [3:0]       w_amt;
    logic             w_multi;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .i_op        (aluk),
        .i_a         (src_a),
        .i_b         (src_b),
        .i_shift_op  (r_op),
        .i_shift_in  (r_result),
        .o_result    (w_comb_res),
        .o_shift_out (w_step_res)
    );

    assign w_amt   = src_b[3:0];
    assign w_multi = is_shift(aluk) && (w_amt != 4'd0);

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_result_nxt = r_result;
        w_done_nxt   = 1'b0;
        w_op_nxt     = r_op;
        w_ldcc_nxt   = r_ldcc;
        w_cc_upd     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_multi) begin
                        w_result_nxt = src_a;
                        w_count_nxt  = w_amt;
                        w_op_nxt     = aluk;
                        w_ldcc_nxt   = ld_cc;
                        w_state_nxt  = ST_SHIFT;
                    end else begin
                        w_result_nxt = w_comb_res;
                        w_done_nxt   = 1'b1;
                        w_cc_upd     = ld_cc;
                    end
                end
            end
            ST_SHIFT: begin
                w_result_nxt = w_step_res;
                w_count_nxt  = r_count - 4'd1;
                if (r_count == 4'd1) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cc_upd    = r_ldcc;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_count  <= 4'd0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_op     <= ALU_ADD;
            r_ldcc   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_result <= w_result_nxt;
            r_done   <= w_done_nxt;
            r_op     <= w_op_nxt;
            r_ldcc   <= w_ldcc_nxt;
        end
    end

    // Codes are taken from the value being written on the completing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n <= CC_N_RST;
            r_z <= CC_Z_RST;
            r_p <= CC_P_RST;
        end else if (w_cc_upd) begin
            r_n <= w_result_nxt[WIDTH-1];
            r_z <= (w_result_nxt == '0);
            r_p <= !w_result_nxt[WIDTH-1] && (w_result_nxt != '0);
        end
    end

    assign busy   = (r_state == ST_SHIFT);
    assign done   = r_done;
    assign result = r_result;
    assign n      = r_n;
    assign z      = r_z;
    assign p      = r_p;

endmodule : alu_exec

`default_nettype wire

// File: tb/tb_alu_exec.sv
// ============================================================================
// Module      : tb_alu_exec
// Description : Directed self-checking bench for alu_exec against a
//               cycle-count behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  aluk  = 3'd0;
    logic [15:0] src_a = 16'h0000;
    logic [15:0] src_b = 16'h0000;
    logic        ld_cc = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        n;
    logic        z;
    logic        p;

    int checks = 0;
    int errors = 0;

    alu_exec #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .aluk   (aluk),
        .src_a  (src_a),
        .src_b  (src_b),
        .ld_cc  (ld_cc),
        .busy   (busy),
        .done   (done),
        .result (result),
        .n      (n),
        .z      (z),
        .p      (p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_op(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [15:0] r;
        logic [3:0]  k;
        k = b[3:0];
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a & b;
            3'd2:    r = a ^ b;
            3'd3:    r = a;
            3'd4:    r = b;
            3'd5:    r = a << k;
            3'd6:    r = a >> k;
            default: r = 16'($signed(a) >>> k);
        endcase
        return r;
    endfunction

    // Model: result of an accepted op appears after (amount) extra cycles.
    logic [15:0] m_result = 16'h0000;
    logic [15:0] m_pres   = 16'h0000;
    logic        m_n = 1'b0, m_z = 1'b1, m_p = 1'b0;
    logic        m_done = 1'b0, m_pend = 1'b0, m_pcc = 1'b0;
    int          m_left = 0;

    task automatic m_setcc(input logic [15:0] v);
        m_n = v[15];
        m_z = (v == 16'h0000);
        m_p = !v[15] && (v != 16'h0000);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_result = 16'h0000;
            m_n = 1'b0; m_z = 1'b1; m_p = 1'b0;
            m_done = 1'b0; m_pend = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_pend) begin
                m_left--;
                if (m_left == 0) begin
                    m_pend   = 1'b0;
                    m_result = m_pres;
                    m_done   = 1'b1;
                    if (m_pcc) m_setcc(m_pres);
                end
            end else if (start) begin
                int k;
                k = (aluk >= 3'd5) ? int'(src_b[3:0]) : 0;
                if (k > 0) begin
                    m_pend = 1'b1;
                    m_left = k;
                    m_pres = ref_op(aluk, src_a, src_b);
                    m_pcc  = ld_cc;
                end else begin
                    m_result = ref_op(aluk, src_a, src_b);
                    m_done   = 1'b1;
                    if (ld_cc) m_setcc(m_result);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_busy", {31'd0, busy}, {31'd0, m_pend});
            chk("cyc_done", {31'd0, done}, {31'd0, m_done});
            if (!m_pend) begin
                chk("cyc_result", {16'd0, result}, {16'd0, m_result});
                chk("cyc_nzp", {29'd0, n, z, p}, {29'd0, m_n, m_z, m_p});
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cc);
        start = 1'b1; aluk = op; src_a = a; src_b = b; ld_cc = cc;
        @(posedge clk); #1;
        start = 1'b0; src_a = 16'hDEAD; src_b = 16'hBEEF; ld_cc = ~cc;
    endtask

    // Called right after drive(): lat counts edges from the start edge.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bc;
        int nd;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_result", {16'd0, result}, 32'h0);
        chk("rst_nzp", {29'd0, n, z, p}, 32'b010);
        chk("rst_busy_done", {30'd0, busy, done}, 32'h0);

        drive(3'd2, 16'h1234, 16'hFFFF, 1'b0);
        wait_done(lat);
        chk("xor_lat", lat, 1);
        chk("xor_result", {16'd0, result}, 32'hEDCB);
        chk("xor_nzp", {29'd0, n, z, p}, 32'b010);

        drive(3'd0, 16'h7FFF, 16'h0001, 1'b1);
        wait_done(lat);
        chk("add_lat", lat, 1);
        chk("add_result", {16'd0, result}, 32'h8000);
        chk("add_nzp", {29'd0, n, z, p}, 32'b100);

        drive(3'd1, 16'h00F0, 16'h0F00, 1'b1);
        wait_done(lat);
        chk("and_result", {16'd0, result}, 32'h0000);
        chk("and_nzp", {29'd0, n, z, p}, 32'b010);

        drive(3'd7, 16'h8010, 16'h0004, 1'b1);
        bc = busy ? 1 : 0;
        start = 1'b1; aluk = 3'd0; src_a = 16'h0001; src_b = 16'h0001; ld_cc = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 2;
        if (busy) bc++;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bc++;
        end
        chk("rshfa_lat", lat, 5);
        chk("rshfa_busy_cycles", bc, 4);
        chk("rshfa_result", {16'd0, result}, 32'hF801);
        chk("rshfa_nzp", {29'd0, n, z, p}, 32'b100);
        nd = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        chk("rshfa_no_second_done", nd, 0);

        drive(3'd5, 16'h0001, 16'h0000, 1'b0);
        wait_done(lat);
        chk("lshf0_lat", lat, 1);
        chk("lshf0_result", {16'd0, result}, 32'h0001);
        drive(3'd5, 16'h0001, 16'h000F, 1'b1);
        wait_done(lat);
        chk("lshf15_lat", lat, 16);
        chk("lshf15_result", {16'd0, result}, 32'h8000);
        chk("lshf15_nzp", {29'd0, n, z, p}, 32'b100);

        drive(3'd6, 16'hABCD, 16'h0008, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_result", {16'd0, result}, 32'h0);
        chk("arst_busy_done", {30'd0, busy, done}, 32'h0);
        chk("arst_nzp", {29'd0, n, z, p}, 32'b010);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) nd++;
        end
        chk("arst_no_done", nd, 0);
        drive(3'd0, 16'h0003, 16'h0004, 1'b1);
        wait_done(lat);
        chk("post_rst_add_lat", lat, 1);
        chk("post_rst_add_result", {16'd0, result}, 32'h0007);
        chk("post_rst_add_nzp", {29'd0, n, z, p}, 32'b001);

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_exec

`default_nettype wire
